// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit ALU datapath: widths, register count and op codes.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

endpackage

// File: rtl/alu16_regfile.sv
// 8x16 register file: synchronous clear, one write port, combinational reads of
// register 0 (accumulator) and of the selected register.
module alu16_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SEL_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Register storage: reset has priority over a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (load) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd0_data = regs_r[0];
    assign rd_data  = regs_r[rd_addr];

endmodule

// File: rtl/alu_16bit.sv
// 16-bit ALU core: operand A is the accumulator, operand B is the immediate or a
// selected register; result and flags are combinational from register contents.
module alu_16bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    input  logic [2:0]        op_select,
    input  logic              load,
    input  logic [SEL_W-1:0]  reg_select,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              NO,
    output logic              ZO,
    output logic [DATA_W-1:0] accumulator
);

    logic [DATA_W-1:0]   op_a_s;
    logic [DATA_W-1:0]   op_b_s;
    logic [DATA_W-1:0]   reg_rd_s;
    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quot_s;
    logic                add_ovf_s;
    logic                sub_ovf_s;
    logic [DATA_W-1:0]   result_s;
    logic                cout_s;
    logic                ovf_s;

    alu16_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .wr_addr  (reg_select),
        .wr_data  (a),
        .rd_addr  (reg_select),
        .rd0_data (op_a_s),
        .rd_data  (reg_rd_s)
    );

    assign op_b_s = (reg_select == 3'd0) ? b : reg_rd_s;

    // Subtraction is A + ~B + 1 so bit 16 is the no-borrow flag directly.
    assign sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
    assign diff_s    = {1'b0, op_a_s} + {1'b0, ~op_b_s} + 17'd1;
    assign prod_s    = {16'h0000, op_a_s} * {16'h0000, op_b_s};
    assign quot_s    = (op_b_s == 16'h0000) ? 16'h0000 : (op_a_s / op_b_s);
    assign add_ovf_s = (op_a_s[15] == op_b_s[15]) && (sum_s[15] != op_a_s[15]);
    assign sub_ovf_s = (op_a_s[15] != op_b_s[15]) && (diff_s[15] != op_a_s[15]);

    // Operation select and per-op flag generation.
    always_comb begin
        result_s = 16'h0000;
        cout_s   = 1'b0;
        ovf_s    = 1'b0;
        case (op_select)
            OP_ADD: begin
                if (sub) begin
                    result_s = diff_s[15:0];
                    cout_s   = diff_s[16];
                    ovf_s    = sub_ovf_s;
                end else begin
                    result_s = sum_s[15:0];
                    cout_s   = sum_s[16];
                    ovf_s    = add_ovf_s;
                end
            end
            OP_SUB: begin
                result_s = diff_s[15:0];
                cout_s   = diff_s[16];
                ovf_s    = sub_ovf_s;
            end
            OP_AND: result_s = op_a_s & op_b_s;
            OP_OR:  result_s = op_a_s | op_b_s;
            OP_MUL: begin
                result_s = prod_s[15:0];
                ovf_s    = |prod_s[31:16];
            end
            OP_DIV: begin
                if (op_b_s == 16'h0000) begin
                    result_s = 16'hFFFF;
                    ovf_s    = 1'b1;
                end else begin
                    result_s = quot_s;
                    ovf_s    = 1'b0;
                end
            end
            OP_XOR: result_s = op_a_s ^ op_b_s;
            OP_NOT: result_s = ~op_a_s;
            default: begin
                result_s = 16'h0000;
                cout_s   = 1'b0;
                ovf_s    = 1'b0;
            end
        endcase
    end

    assign result      = result_s;
    assign cout        = cout_s;
    assign overflow    = ovf_s;
    assign NO          = result_s[15];
    assign ZO          = (result_s == 16'h0000);
    assign accumulator = op_a_s;

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed literal checks from the test plan
// plus randomized stimulus compared every cycle against an arithmetic model.
module tb_alu_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        sub = 1'b0;
    logic [2:0]  op_select = 3'b000;
    logic        load = 1'b0;
    logic [2:0]  reg_select = 3'b000;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        NO;
    logic        ZO;
    logic [15:0] accumulator;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic        model_valid = 1'b0;

    alu_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .op_select   (op_select),
        .load        (load),
        .reg_select  (reg_select),
        .result      (result),
        .cout        (cout),
        .overflow    (overflow),
        .NO          (NO),
        .ZO          (ZO),
        .accumulator (accumulator)
    );

    always #5 clk = ~clk;

    // Reference register state, updated at the same edge as the design.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
            model_valid <= 1'b1;
        end else if (load) begin
            m_regs[reg_select] <= a;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int to_signed16(input int unsigned v);
        return (v >= 32768) ? (int'(v) - 65536) : int'(v);
    endfunction

    // Expected outputs from plain integer arithmetic on the reference registers.
    task automatic check_model();
        int unsigned ua, ub, r;
        longint unsigned p;
        int sres;
        bit c, ov;
        ua = m_regs[0];
        ub = (reg_select == 3'd0) ? b : m_regs[reg_select];
        r = 0; c = 1'b0; ov = 1'b0;
        if ((op_select == 3'd0 && sub) || op_select == 3'd1) begin
            r    = (ua - ub) & 32'hFFFF;
            c    = (ua >= ub);
            sres = to_signed16(ua) - to_signed16(ub);
            ov   = (sres > 32767) || (sres < -32768);
        end else if (op_select == 3'd0) begin
            r    = (ua + ub) & 32'hFFFF;
            c    = (ua + ub) > 32'hFFFF;
            sres = to_signed16(ua) + to_signed16(ub);
            ov   = (sres > 32767) || (sres < -32768);
        end else if (op_select == 3'd2) begin
            r = ua & ub;
        end else if (op_select == 3'd3) begin
            r = ua | ub;
        end else if (op_select == 3'd4) begin
            p  = longint'(ua) * longint'(ub);
            r  = int'(p % 65536);
            ov = (p > 65535);
        end else if (op_select == 3'd5) begin
            if (ub == 0) begin
                r = 32'hFFFF; ov = 1'b1;
            end else begin
                r = ua / ub;
            end
        end else if (op_select == 3'd6) begin
            r = ua ^ ub;
        end else begin
            r = (~ua) & 32'hFFFF;
        end
        chk("model_result", {16'h0000, result}, r);
        chk("model_cout", {31'd0, cout}, {31'd0, c});
        chk("model_overflow", {31'd0, overflow}, {31'd0, ov});
        chk("model_NO", {31'd0, NO}, (r >= 32768) ? 32'd1 : 32'd0);
        chk("model_ZO", {31'd0, ZO}, (r == 0) ? 32'd1 : 32'd0);
        chk("model_acc", {16'h0000, accumulator}, ua);
    endtask

    // Apply one cycle of inputs at the falling edge and check outputs shortly after.
    task automatic drive(input logic r, input logic l, input logic [2:0] rs,
                         input logic [15:0] aa, input logic [15:0] bb,
                         input logic [2:0] op, input logic s);
        @(negedge clk);
        rst = r; load = l; reg_select = rs; a = aa; b = bb; op_select = op; sub = s;
        #1;
        if (model_valid) check_model();
    endtask

    task automatic lit(input string nm, input logic [15:0] er, input logic ec,
                       input logic eo, input logic en, input logic ez);
        chk({nm, "_result"}, {16'h0000, result}, {16'h0000, er});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({nm, "_NO"}, {31'd0, NO}, {31'd0, en});
        chk({nm, "_ZO"}, {31'd0, ZO}, {31'd0, ez});
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        chk("reset_acc", {16'h0000, accumulator}, 32'h0000);
        lit("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 3'd0, 16'h0010, 16'h0000, 3'd0, 1'b0);
        chk("rbw_acc_old", {16'h0000, accumulator}, 32'h0000);
        drive(1'b0, 1'b1, 3'd1, 16'h0020, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd0, 1'b0);
        chk("load_acc", {16'h0000, accumulator}, 32'h0010);
        lit("add", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd1, 1'b0);
        lit("sub_op1", 16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd0, 1'b1);
        lit("sub_mod", 16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd2, 1'b0);
        lit("and", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd3, 1'b0);
        lit("or", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd6, 1'b0);
        lit("xor", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd7, 1'b0);
        lit("not", 16'hFFEF, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd4, 1'b0);
        lit("mul", 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd5, 1'b0);
        lit("div", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 3'd0, 16'h0100, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 3'd1, 16'h0100, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd4, 1'b0);
        lit("mul_ovf", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 1'b0);
        lit("div0", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 3'd0, 16'h7FFF, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0001, 3'd0, 1'b0);
        lit("add_sovf", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0001, 3'd0, 1'b0);
        lit("add_carry", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset together with a load: reset wins and register 3 stays clear.
        drive(1'b0, 1'b1, 3'd3, 16'h5A5A, 16'h0000, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 3'd3, 16'h1234, 16'h0000, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 3'd3, 1'b0);
        lit("rst_wins", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_wins_acc", {16'h0000, accumulator}, 32'h0000);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 2)) | 16'h7FFE;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)), ra, rb,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
